// File: rtl/ccff_chain_loader.sv
// Purpose : writer/readback end of a tile configuration chain; serializes words LSB-first onto the chain head and captures the bits falling out of the tail.
// Latency : word accepted on edge N drives its first bit (shift_en=1) in cycle N+1; rd_valid pulses the cycle after that word's last shift.
// Backpr. : wr_ready only in WAIT_WORD (producer may stall indefinitely); rd_valid/done are strobes with no backpressure.
//
// Ports:
//   clk, reset (async, active-low)     start/busy : load request and in-progress flag
//   wr_data/wr_valid/wr_ready          : configuration word input handshake
//   ccff_head/ccff_shift_en/ccff_tail  : serial chain interface
//   rd_data/rd_valid                   : readback of previous chain contents
//   done                               : one-cycle pulse after CHAIN_LEN shifts
module ccff_chain_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done
);

    // Counters must hold both CHAIN_LEN and WORD_W, whichever is larger.
    localparam int MAX_N = (CHAIN_LEN > WORD_W) ? CHAIN_LEN : WORD_W;
    localparam int CNT_W = $clog2(MAX_N + 1);
    localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] WORD_C = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, WAIT_WORD, SHIFT, DONE} state_t;

    state_t            state, state_nxt;
    logic [WORD_W-1:0] sreg, rsreg, rs_nxt;
    logic [CNT_W-1:0]  tcnt, wcnt, nbits, remain;
    logic              shift_q;
    logic              accept, last_shift;

    assign accept     = (state == WAIT_WORD) && wr_valid;
    assign remain     = LEN_C - tcnt;
    assign last_shift = shift_q && ((wcnt + ONE_C) == nbits);

    // Both chain-facing outputs come straight from flops.
    assign ccff_head     = sreg[0];
    assign ccff_shift_en = shift_q;

    // Readback register with the tail bit of this cycle merged at position wcnt.
    always_comb begin
        rs_nxt = rsreg;
        for (int i = 0; i < WORD_W; i++) begin
            if (wcnt == CNT_W'(i)) begin
                rs_nxt[i] = ccff_tail;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // SHIFT covers the nbits shift cycles plus one trailing cycle with
    // shift_en low in which rd_valid is presented; leaving only after that
    // cycle keeps rd_valid and done apart and guarantees a gap between words.
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        wr_ready  = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = WAIT_WORD;
            end
            WAIT_WORD: begin
                wr_ready = 1'b1;
                if (wr_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (!shift_q) state_nxt = (tcnt == LEN_C) ? DONE : WAIT_WORD;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg     <= '0;
            rsreg    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            tcnt     <= '0;
            wcnt     <= '0;
            nbits    <= '0;
            shift_q  <= 1'b0;
        end else begin
            rd_valid <= last_shift;
            if (state == IDLE && start) begin
                tcnt <= '0;
            end
            if (accept) begin
                sreg    <= wr_data;
                // The final word may be partial; its upper bits are never shifted.
                nbits   <= (remain < WORD_C) ? remain : WORD_C;
                wcnt    <= '0;
                rsreg   <= '0;
                shift_q <= 1'b1;
            end else if (shift_q) begin
                sreg  <= sreg >> 1;
                rsreg <= rs_nxt;
                wcnt  <= wcnt + ONE_C;
                tcnt  <= tcnt + ONE_C;
                if (last_shift) begin
                    shift_q <= 1'b0;
                    rd_data <= rs_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
`timescale 1ns/1ps
module tb_ccff_chain_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       busy;
    logic [7:0] wr_data = 8'h00;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic       ccff_head;
    logic       ccff_shift_en;
    logic       ccff_tail;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       done;

    int chk = 0;
    int pass = 0;
    int timeouts = 0;
    int stall_bad = 0;

    always #5 clk = ~clk;

    ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(20)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done)
    );

    // Behavioural 20-flop chain: chain[0] next to the head, chain[19] is the tail.
    logic [19:0] chain = 20'h0;
    assign ccff_tail = chain[19];
    always @(posedge clk) begin
        if (ccff_shift_en) chain <= {chain[18:0], ccff_head};
    end

    // Monitor: only this block writes the histories; tests compare against snapshots.
    int         shift_total = 0;
    int         run_len = 0;
    int         done_cnt = 0;
    int         coincide = 0;
    int         runs[$];
    logic [7:0] rd_q[$];
    logic       head_q[$];
    always @(negedge clk) begin
        if (ccff_shift_en) begin
            head_q.push_back(ccff_head);
            shift_total++;
            run_len++;
        end else if (run_len > 0) begin
            runs.push_back(run_len);
            run_len = 0;
        end
        if (rd_valid) rd_q.push_back(rd_data);
        if (done) done_cnt++;
        if (rd_valid && done) coincide++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] head_sig(int b);
        logic [19:0] v = '0;
        for (int k = 0; k < 20; k++)
            if (b + k < head_q.size()) v[k] = head_q[b + k];
        return v;
    endfunction

    function automatic logic [31:0] runs_sig(int b);
        if (runs.size() < b + 3) return 32'hFFFF_FFFF;
        return {8'(runs.size() - b), 8'(runs[b]), 8'(runs[b + 1]), 8'(runs[b + 2])};
    endfunction

    function automatic logic [31:0] rd_sig(int b);
        if (rd_q.size() < b + 3) return 32'hFFFF_FFFF;
        return {8'(rd_q.size() - b), rd_q[b], rd_q[b + 1], rd_q[b + 2]};
    endfunction

    task automatic run_load(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                            input int stall, input bit poke);
        logic [7:0] w[3];
        int n;
        bit rdy;
        w = '{w0, w1, w2};
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (stall > 0) begin
                wr_valid = 1'b0;
                n = 0;
                while (wr_ready !== 1'b1 && n < 200) begin tick(); n++; end
                if (n >= 200) timeouts++;
                repeat (stall) begin
                    @(negedge clk);
                    if (wr_ready !== 1'b1 || ccff_shift_en !== 1'b0) stall_bad++;
                    tick();
                end
            end
            wr_data = w[i]; wr_valid = 1'b1;
            n = 0; rdy = 1'b0;
            while (!rdy && n < 200) begin
                @(negedge clk); rdy = wr_ready; tick(); n++;
            end
            if (!rdy) timeouts++;
            if (poke && i == 0) begin start = 1'b1; tick(); start = 1'b0; end
        end
        wr_valid = 1'b0;
        n = 0;
        begin
            int d0 = done_cnt;
            while (done_cnt == d0 && n < 200) begin tick(); n++; end
            if (n >= 200) timeouts++;
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        start = 1'b1; wr_valid = 1'b1; wr_data = 8'hFF;
        repeat (3) tick();
        chk++;
        if ({busy, wr_ready, ccff_head, ccff_shift_en, rd_valid, done} !== 6'b0)
            $display("FAIL reset_ctl got %b want 000000", {busy, wr_ready, ccff_head, ccff_shift_en, rd_valid, done});
        else pass++;
        chk++;
        if (rd_data !== 8'h00) $display("FAIL reset_rd_data got %h want 00", rd_data); else pass++;
        start = 1'b0; wr_valid = 1'b0;
        reset = 1'b1;
        repeat (50) tick();
        chk++;
        if (shift_total !== 0) $display("FAIL reset_idle_shift got %0d want 0", shift_total); else pass++;
        chk++;
        if (busy !== 1'b0) $display("FAIL reset_idle_busy got %b want 0", busy); else pass++;
    endtask

    task automatic test_idle_ignore();
        int sb = shift_total;
        int bad = 0;
        wr_valid = 1'b1; wr_data = 8'hAA;
        repeat (20) begin
            @(negedge clk);
            if (wr_ready !== 1'b0) bad++;
            tick();
        end
        wr_valid = 1'b0;
        chk++;
        if (bad != 0) $display("FAIL idle_wr_ready got %0d ready cycles want 0", bad); else pass++;
        chk++;
        if (shift_total - sb != 0) $display("FAIL idle_shift got %0d want 0", shift_total - sb); else pass++;
        chk++;
        if (busy !== 1'b0) $display("FAIL idle_busy got %b want 0", busy); else pass++;
    endtask

    task automatic test_full_load();
        int sb = shift_total, rb = rd_q.size(), hb = runs.size(), db = done_cnt, cb = coincide, tb0 = timeouts;
        run_load(8'hA5, 8'h3C, 8'h0F, 0, 1'b0);
        chk++;
        if (head_sig(sb) !== 20'hF3CA5) $display("FAIL full_head got %h want f3ca5", head_sig(sb)); else pass++;
        chk++;
        if (shift_total - sb != 20) $display("FAIL full_shift_count got %0d want 20", shift_total - sb); else pass++;
        chk++;
        if (runs_sig(hb) !== 32'h03080804) $display("FAIL full_runs got %h want 03080804", runs_sig(hb)); else pass++;
        chk++;
        if (rd_sig(rb) !== 32'h03000000) $display("FAIL full_rd got %h want 03000000", rd_sig(rb)); else pass++;
        chk++;
        if (done_cnt - db != 1) $display("FAIL full_done got %0d want 1", done_cnt - db); else pass++;
        chk++;
        if (coincide - cb != 0) $display("FAIL full_rd_done_overlap got %0d want 0", coincide - cb); else pass++;
        chk++;
        if (chain !== 20'hA53CF) $display("FAIL full_chain got %h want a53cf", chain); else pass++;
        chk++;
        if (timeouts != tb0 || busy !== 1'b0) $display("FAIL full_end got to=%0d busy=%b want 0 0", timeouts - tb0, busy); else pass++;
    endtask

    task automatic test_readback();
        int sb = shift_total, rb = rd_q.size(), db = done_cnt, tb0 = timeouts;
        run_load(8'h11, 8'h22, 8'h03, 0, 1'b0);
        chk++;
        if (rd_sig(rb) !== 32'h03A53C0F) $display("FAIL rb_rd got %h want 03a53c0f", rd_sig(rb)); else pass++;
        chk++;
        if (chain !== 20'h8844C) $display("FAIL rb_chain got %h want 8844c", chain); else pass++;
        chk++;
        if (shift_total - sb != 20 || done_cnt - db != 1 || timeouts != tb0)
            $display("FAIL rb_counts got shifts=%0d done=%0d to=%0d want 20 1 0", shift_total - sb, done_cnt - db, timeouts - tb0);
        else pass++;
    endtask

    task automatic test_stall();
        int hb = runs.size(), rb = rd_q.size(), db = done_cnt, tb0 = timeouts;
        stall_bad = 0;
        run_load(8'hA5, 8'h3C, 8'h0F, 5, 1'b0);
        chk++;
        if (stall_bad != 0) $display("FAIL stall_wait got %0d bad cycles want 0", stall_bad); else pass++;
        chk++;
        if (rd_sig(rb) !== 32'h03112203) $display("FAIL stall_rd got %h want 03112203", rd_sig(rb)); else pass++;
        chk++;
        if (runs_sig(hb) !== 32'h03080804) $display("FAIL stall_runs got %h want 03080804", runs_sig(hb)); else pass++;
        chk++;
        if (chain !== 20'hA53CF) $display("FAIL stall_chain got %h want a53cf", chain); else pass++;
        chk++;
        if (done_cnt - db != 1 || timeouts != tb0)
            $display("FAIL stall_counts got done=%0d to=%0d want 1 0", done_cnt - db, timeouts - tb0);
        else pass++;
    endtask

    task automatic test_start_during_shift();
        int sb = shift_total, rb = rd_q.size(), db = done_cnt;
        run_load(8'h11, 8'h22, 8'h03, 0, 1'b1);
        repeat (30) tick();
        chk++;
        if (done_cnt - db != 1) $display("FAIL poke_done got %0d want 1", done_cnt - db); else pass++;
        chk++;
        if (shift_total - sb != 20) $display("FAIL poke_shifts got %0d want 20", shift_total - sb); else pass++;
        chk++;
        if (rd_sig(rb) !== 32'h03A53C0F) $display("FAIL poke_rd got %h want 03a53c0f", rd_sig(rb)); else pass++;
        chk++;
        if (chain !== 20'h8844C || busy !== 1'b0) $display("FAIL poke_end got chain=%h busy=%b want 8844c 0", chain, busy); else pass++;
    endtask

    task automatic test_reset_mid();
        int sb = shift_total, rb = rd_q.size(), db = done_cnt, n = 0;
        start = 1'b1; tick(); start = 1'b0;
        wr_data = 8'hFF; wr_valid = 1'b1;
        while (shift_total - sb < 10 && n < 200) begin tick(); n++; end
        chk++;
        if (n >= 200) $display("FAIL mid_wait got timeout want 10 shifts"); else pass++;
        reset = 1'b0;
        #1;
        chk++;
        if ({busy, wr_ready, ccff_head, ccff_shift_en, rd_valid, done} !== 6'b0 || rd_data !== 8'h00)
            $display("FAIL mid_reset_out got %b rd=%h want 000000 00", {busy, wr_ready, ccff_head, ccff_shift_en, rd_valid, done}, rd_data);
        else pass++;
        wr_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (10) tick();
        chk++;
        if (done_cnt - db != 0 || shift_total - sb != 10)
            $display("FAIL mid_no_done got done=%0d shifts=%0d want 0 10", done_cnt - db, shift_total - sb);
        else pass++;
        chk++;
        if (rd_q.size() - rb != 1 || rd_q[rb] !== 8'h11)
            $display("FAIL mid_rd got n=%0d want 1 word 11", rd_q.size() - rb);
        else pass++;
        chk++;
        if (chain !== 20'h133FF) $display("FAIL mid_chain got %h want 133ff", chain); else pass++;
        rb = rd_q.size(); db = done_cnt; sb = shift_total;
        run_load(8'hA5, 8'h3C, 8'h0F, 0, 1'b0);
        chk++;
        if (rd_sig(rb) !== 32'h03C8FC0F) $display("FAIL mid_reload_rd got %h want 03c8fc0f", rd_sig(rb)); else pass++;
        chk++;
        if (chain !== 20'hA53CF || done_cnt - db != 1 || shift_total - sb != 20)
            $display("FAIL mid_reload got chain=%h done=%0d shifts=%0d want a53cf 1 20", chain, done_cnt - db, shift_total - sb);
        else pass++;
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_full_load();
        test_readback();
        test_stall();
        test_start_during_shift();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Drives a tile's configuration-chain flip-flops. It is the writer and readback end of the serial chain that the tile DFFs capture from.
- Accepts configuration words over a valid/ready interface and serializes them LSB-first onto the chain head with a shift enable.
- Captures the bits that fall out of the chain tail during the same shifts and returns them as words, so the previous chain contents are read back.
- Sits between the bitstream source and the first tile of a chain.

Parameters:
- WORD_W, 8, width of write/readback words (≥2).
- CHAIN_LEN, 20, total flip-flops in the chain (≥1). Need not be a multiple of WORD_W.

Ports:
- clk  input  1  single clock for the block and the chain flops.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  one-cycle request to begin a full-chain load.
- busy  output  1  high from accepted start until done pulse inclusive.
- wr_data  input  WORD_W  next configuration word, bit 0 shifted first.
- wr_valid  input  1  wr_data valid.
- wr_ready  output  1  block can accept wr_data this cycle.
- ccff_head  output  1  serial data into chain head.
- ccff_shift_en  output  1  chain flops capture ccff_head on the clk edge while high.
- ccff_tail  input  1  serial data from chain tail.
- rd_data  output  WORD_W  readback word, first tail bit in bit 0.
- rd_valid  output  1  one-cycle strobe, rd_data valid; no backpressure.
- done  output  1  one-cycle pulse when CHAIN_LEN bits have been shifted.

Behaviour:
- Reset (reset=0, async): state IDLE, bit counters 0, shift/readback registers 0. busy, wr_ready, ccff_head, ccff_shift_en, rd_valid, rd_data and done all 0.
- FSM states: IDLE, WAIT_WORD, SHIFT, DONE.
- IDLE:
  - start=1 → WAIT_WORD; busy=1 from the next cycle; total counter tcnt=0.
  - wr_valid in IDLE is ignored.
- WAIT_WORD:
  - wr_ready=1.
  - On wr_valid&wr_ready: load sreg=wr_data; nbits=min(WORD_W, CHAIN_LEN−tcnt); wcnt=0; clear rsreg; → SHIFT.
- SHIFT:
  - ccff_shift_en=1 and ccff_head=sreg[0], both driven from registers with no combinational path from inputs.
  - Each cycle: sreg>>=1; rsreg[wcnt]=ccff_tail (sampled on the same edge the chain shifts); wcnt++, tcnt++.
  - After nbits cycles: rd_data=rsreg with bit nbits−1 included; bits ≥nbits are zero. rd_valid pulses 1 cycle on the cycle after the last shift.
  - Then: if tcnt==CHAIN_LEN → DONE, else → WAIT_WORD.
- Latency: a word accepted on edge N puts its first bit on ccff_head with shift_en=1 in cycle N+1. There is at least one shift_en=0 cycle between words; the chain holds its value during gaps.
- Partial last word: only nbits are shifted. Unused upper wr_data bits are discarded.
- DONE: done=1 and busy=1 for one cycle → IDLE; busy=0 in the following cycle.
- Total shift_en-high cycles per load = CHAIN_LEN exactly. Number of words accepted = ceil(CHAIN_LEN/WORD_W).
- start while busy is ignored. wr_valid outside WAIT_WORD is not accepted (wr_ready=0).
- Reset mid-load: immediate return to reset values. The chain is left partially shifted; no done and no rd_valid are issued.
- rd_valid and done never coincide.

Test Plan:
- Reset: hold reset=0 with start=1 and wr_valid=1 → all outputs 0. After release with no start, shift_en stays 0 for 50 cycles.
- Full load, CHAIN_LEN=20, WORD_W=8, behavioural 20-flop chain model preloaded 0:
  - Start, then words 0xA5, 0x3C, 0x0F with wr_valid held → head sequence 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1.
  - shift_en high for exactly 20 cycles in runs of 8, 8 and 4.
  - rd_data 0x00, 0x00, 0x00; one done pulse.
- Readback: repeat the load with words 0x11, 0x22, 0x03 → rd_data 0xA5, 0x3C, 0x0F. Chain model then holds the new pattern.
- Stalled producer: insert 5 idle cycles before each wr_valid → wr_ready stays 1 while waiting, shift_en stays 0, ccff_head value is irrelevant. Final chain contents match the no-stall case.
- Ignored requests:
  - wr_valid=1 in IDLE → no acceptance.
  - start pulsed during SHIFT → no restart; one done only.
- Reset mid-operation: assert reset after 10 shifts → outputs 0 immediately, no done. A new start afterwards performs a full 20-bit load correctly.
